fir_tap_buffer: RTL and testbench

Nios II multi-cycle custom instruction holding a FIR sample delay line and a coefficient table in on-chip RAM. It sits directly upstream of the MAC custom instruction. Software pushes input samples, then loops over taps: it reads sample k and coefficient k from this block and hands both to the MAC as `dataa`/`datab`. It uses the same `start`/`done`/`n` custom-instruction handshake as the MAC.

---
 rtl/fir_tap_defs.sv | 23 ++
 rtl/tap_ram.sv | 32 +++
 rtl/fir_tap_buffer.sv | 169 ++++++++++++++++
 tb/tb_fir_tap_buffer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fir_tap_defs.sv
// Shared opcodes, FSM encoding and helpers for the FIR tap buffer custom instruction.
package fir_tap_defs;

  localparam int unsigned DATA_W = 32;

  // Custom-instruction opcodes carried on n.
  localparam logic [7:0] OP_PUSH    = 8'd0;
  localparam logic [7:0] OP_TAP     = 8'd1;
  localparam logic [7:0] OP_COEF_WR = 8'd2;
  localparam logic [7:0] OP_COEF_RD = 8'd3;
  localparam logic [7:0] OP_CLEAR   = 8'd4;

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_RD_WAIT = 1'b1
  } fir_state_e;

  // Read-class ops need a RAM access and therefore an extra cycle.
  function automatic logic is_read_op(input logic [7:0] op);
    return (op == OP_TAP) || (op == OP_COEF_RD);
  endfunction

endpackage

// File: rtl/tap_ram.sv
// Simple dual-port synchronous RAM: one write port, one read port with a registered,
// enable-gated output. Contents are never reset.
module tap_ram #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port and registered read port; the output holds whenever re_i is low.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fir_tap_buffer.sv
// FIR sample delay line plus coefficient table, exposed as a Nios II multi-cycle
// custom instruction. Write-class ops complete in one cycle, read-class ops in two.
module fir_tap_buffer
  import fir_tap_defs::*;
#(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [7:0]  n,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [ADDR_W-1:0] PtrOne   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CountMax = (ADDR_W + 1)'(DEPTH);

  fir_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   result_q, result_d;
  // Which RAM the pending read targets, and whether a tap index was in range.
  logic                rd_coef_q, rd_coef_d;
  logic                tap_ok_q, tap_ok_d;

  logic                smp_we, smp_re;
  logic [ADDR_W-1:0]   smp_raddr;
  logic [DATA_W-1:0]   smp_rdata;
  logic                coef_we, coef_re;
  logic [DATA_W-1:0]   coef_rdata;
  logic                k_in_range;

  // Tap 0 is the newest sample, i.e. the slot just behind the write pointer.
  assign smp_raddr  = wr_ptr_q - PtrOne - datab[ADDR_W-1:0];
  // Full-width compare so large k never aliases onto a valid tap.
  assign k_in_range = datab < 32'(count_q);

  tap_ram #(
    .DEPTH  (DEPTH),
    .WIDTH  (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_sample_ram (
    .clk_i   (clk),
    .we_i    (smp_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (dataa),
    .re_i    (smp_re),
    .raddr_i (smp_raddr),
    .rdata_o (smp_rdata)
  );

  tap_ram #(
    .DEPTH  (DEPTH),
    .WIDTH  (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_coef_ram (
    .clk_i   (clk),
    .we_i    (coef_we),
    .waddr_i (datab[ADDR_W-1:0]),
    .wdata_i (dataa),
    .re_i    (coef_re),
    .raddr_i (dataa[ADDR_W-1:0]),
    .rdata_o (coef_rdata)
  );

  // Next-state, opcode decode and RAM strobes; everything holds while clk_en is low.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    done_d    = done_q;
    result_d  = result_q;
    rd_coef_d = rd_coef_q;
    tap_ok_d  = tap_ok_q;
    smp_we    = 1'b0;
    smp_re    = 1'b0;
    coef_we   = 1'b0;
    coef_re   = 1'b0;

    // Reset gates the RAM strobes too, so a start during reset cannot write.
    if (clk_en && reset) begin
      done_d = 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (is_read_op(n)) begin
              state_d = S_RD_WAIT;
            end else begin
              done_d = 1'b1;
            end
            case (n)
              OP_PUSH: begin
                smp_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + PtrOne;
                count_d  = (count_q == CountMax) ? count_q : count_q + 1'b1;
                result_d = 32'(count_d);
              end
              OP_TAP: begin
                smp_re    = 1'b1;
                rd_coef_d = 1'b0;
                tap_ok_d  = k_in_range;
              end
              OP_COEF_WR: begin
                coef_we  = 1'b1;
                result_d = '0;
              end
              OP_COEF_RD: begin
                coef_re   = 1'b1;
                rd_coef_d = 1'b1;
                tap_ok_d  = 1'b1;
              end
              OP_CLEAR: begin
                wr_ptr_d = '0;
                count_d  = '0;
                result_d = '0;
              end
              default: begin
                result_d = '0;
              end
            endcase
          end
        end
        S_RD_WAIT: begin
          if (rd_coef_q) begin
            result_d = coef_rdata;
          end else begin
            result_d = tap_ok_q ? smp_rdata : '0;
          end
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
      result_q  <= '0;
      rd_coef_q <= 1'b0;
      tap_ok_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      done_q    <= done_d;
      result_q  <= result_d;
      rd_coef_q <= rd_coef_d;
      tap_ok_q  <= tap_ok_d;
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_fir_tap_buffer.sv
// Scoreboard bench for fir_tap_buffer: the driver queues expected result and completion
// cycle per instruction, a monitor pops and compares on every qualified done.
module tb_fir_tap_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clk_en = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  n = '0;
  logic [31:0] dataa = '0;
  logic [31:0] datab = '0;
  logic        done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_spur = 0;

  fir_tap_buffer #(
    .DEPTH  (32),
    .ADDR_W (5)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .start  (start),
    .n      (n),
    .dataa  (dataa),
    .datab  (datab),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Issue one instruction, queue its expectation and wait (bounded) for completion.
  task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input int lat, input string name,
                       input bit stall);
    exp_t e;
    @(posedge clk);
    #1;
    start = 1'b1;
    n     = op;
    dataa = a;
    datab = b;
    e.res  = exp_res;
    e.cyc  = cyc + lat + (stall ? 4 : 0);
    e.name = name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    if (stall) begin
      clk_en = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      clk_en = 1'b1;
    end
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no done within bound, got none required done", name);
      sb.delete();
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    fork
      // Monitor: compare every qualified done against the scoreboard head.
      begin : monitor
        bit prev_done = 1'b0;
        forever begin
          @(negedge clk);
          if (reset === 1'b1 && clk_en === 1'b1 && done === 1'b1) begin
            if (prev_done) begin
              n_cmp++;
              n_bad++;
              $display("FAIL done_back_to_back: got done in consecutive cycles, required one");
            end
            if (sb.size() == 0) begin
              n_spur++;
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_done: got done at cycle %0d, required none", cyc);
            end else begin
              exp_t e;
              e = sb.pop_front();
              n_cmp++;
              if (result !== e.res) begin
                n_bad++;
                $display("FAIL %s result: got %h required %h", e.name, result, e.res);
              end
              n_cmp++;
              if (cyc != e.cyc) begin
                n_bad++;
                $display("FAIL %s latency: done at cycle %0d required %0d", e.name, cyc, e.cyc);
              end
            end
            prev_done = 1'b1;
          end else if (clk_en === 1'b1) begin
            prev_done = 1'b0;
          end
        end
      end
      begin : stimulus
        int spur_before;
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin
          n_bad++;
          $display("FAIL reset_done: got %b required 0", done);
        end
        n_cmp++;
        if (result !== 32'h0) begin
          n_bad++;
          $display("FAIL reset_result: got %h required 0", result);
        end
        issue(8'd1, 32'h0, 32'd0, 32'h0, 2, "tap0_after_reset", 1'b0);

        // Push and tap.
        issue(8'd0, 32'h11, 32'h0, 32'd1, 1, "push_11", 1'b0);
        issue(8'd0, 32'h22, 32'h0, 32'd2, 1, "push_22", 1'b0);
        issue(8'd0, 32'h33, 32'h0, 32'd3, 1, "push_33", 1'b0);
        issue(8'd1, 32'h0, 32'd0, 32'h33, 2, "tap0", 1'b0);
        issue(8'd1, 32'h0, 32'd2, 32'h11, 2, "tap2", 1'b0);
        issue(8'd1, 32'h0, 32'd3, 32'h0, 2, "tap3_oob", 1'b0);
        issue(8'd1, 32'h0, 32'h8000_0000, 32'h0, 2, "tap_big_k", 1'b0);

        // Wrap-around with saturation.
        issue(8'd4, 32'h0, 32'h0, 32'h0, 1, "clear_pre_wrap", 1'b0);
        for (int i = 1; i <= 40; i++) begin
          issue(8'd0, i, 32'h0, (i > 32) ? 32'd32 : i, 1, "push_wrap", 1'b0);
        end
        issue(8'd1, 32'h0, 32'd0, 32'd40, 2, "wrap_tap0", 1'b0);
        issue(8'd1, 32'h0, 32'd31, 32'd9, 2, "wrap_tap31", 1'b0);
        issue(8'd1, 32'h0, 32'd32, 32'd0, 2, "wrap_tap32", 1'b0);

        // Coefficient table, including index aliasing.
        issue(8'd2, 32'hDEAD_BEEF, 32'd5, 32'h0, 1, "coef_wr5", 1'b0);
        issue(8'd3, 32'd5, 32'h0, 32'hDEAD_BEEF, 2, "coef_rd5", 1'b0);
        issue(8'd3, 32'd37, 32'h0, 32'hDEAD_BEEF, 2, "coef_rd37", 1'b0);

        // clk_en stall during RD_WAIT delays done by exactly 4 cycles.
        issue(8'd1, 32'h0, 32'd0, 32'd40, 2, "stall_tap0", 1'b1);

        // Unknown opcode: write-class completion, no state change.
        issue(8'h7F, 32'h1234, 32'h0, 32'h0, 1, "op_7f", 1'b0);
        issue(8'd1, 32'h0, 32'd0, 32'd40, 2, "tap0_after_7f", 1'b0);
        issue(8'd1, 32'h0, 32'd31, 32'd9, 2, "tap31_after_7f", 1'b0);

        // Reset in RD_WAIT aborts without a done pulse.
        spur_before = n_spur;
        @(posedge clk);
        #1;
        start = 1'b1;
        n     = 8'd1;
        datab = 32'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if (n_spur != spur_before) begin
          n_bad++;
          $display("FAIL abort_no_done: got %0d done pulses required 0", n_spur - spur_before);
        end
        issue(8'd1, 32'h0, 32'd0, 32'h0, 2, "tap0_after_abort", 1'b0);

        // CLEAR after five pushes.
        for (int i = 1; i <= 5; i++) begin
          issue(8'd0, 32'h100 + i, 32'h0, i, 1, "push_pre_clear", 1'b0);
        end
        issue(8'd1, 32'h0, 32'd4, 32'h101, 2, "tap4_pre_clear", 1'b0);
        issue(8'd4, 32'h0, 32'h0, 32'h0, 1, "clear", 1'b0);
        issue(8'd1, 32'h0, 32'd0, 32'h0, 2, "tap0_after_clear", 1'b0);
        issue(8'd0, 32'hABCD, 32'h0, 32'd1, 1, "push_after_clear", 1'b0);
        issue(8'd1, 32'h0, 32'd0, 32'hABCD, 2, "tap0_after_push", 1'b0);
        issue(8'd3, 32'd5, 32'h0, 32'hDEAD_BEEF, 2, "coef_kept", 1'b0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
    join
  end

endmodule
